// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the
// instruction prefetch controller and its FIFOs.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_GNT
  } pf_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } pf_entry_t;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: small synchronous FIFO with flush and
// occupancy count; head is read straight from storage.
module pf_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_i) begin
        rd_q <= inc(rd_q);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_prefetch_ctrl.sv
// instr_prefetch_ctrl: credit-limited instruction
// prefetcher with redirect flush and response drop.
import core_pkg::*;

module instr_prefetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          NUM_REQS = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int CW = $clog2(NUM_REQS + 1);

  pf_state_e   state_q, state_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] hold_q, hold_d;
  logic [CW-1:0] disc_q, disc_d;
  logic        stale_q, stale_d;
  logic        hw_q, hw_d;

  logic [CW-1:0] outst;
  logic [CW-1:0] rsp_cnt;
  logic [31:0]   tag_addr;
  logic [CW:0]   occ;
  logic          credit;
  logic          fire;
  logic          rv_land;
  logic          rsp_push;
  logic          rsp_pop;
  pf_entry_t     rsp_in;
  pf_entry_t     rsp_head;

  assign rv_land = mem_rvalid_i && (outst != '0);
  assign out_valid_o = (rsp_cnt != '0);
  assign rsp_pop = out_valid_o && out_ready_i;

  // A pop this cycle frees its slot before any new word can land.
  assign occ = {1'b0, rsp_cnt} + {1'b0, outst}
             - {{CW{1'b0}}, rsp_pop};
  assign credit = occ < (CW + 1)'(NUM_REQS);

  assign mem_req_o = (state_q == WAIT_GNT) ||
                     ((state_q == REQ) && credit);
  assign mem_addr_o = (state_q == WAIT_GNT) ? hold_q : fetch_q;
  assign fire = mem_req_o && mem_gnt_i;

  assign rsp_push = rv_land && (disc_q == '0) && !redirect_i;

  assign rsp_in = '{
    rdata: mem_rdata_i,
    addr:  tag_addr | {30'b0, hw_q, 1'b0},
    err:   mem_err_i
  };

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    hold_d  = hold_q;
    disc_d  = disc_q;
    stale_d = stale_q;
    hw_d    = hw_q;
    unique case (state_q)
      IDLE: begin
        if (req_en_i && credit) state_d = REQ;
      end
      REQ: begin
        if (fire) begin
          state_d = req_en_i ? REQ : IDLE;
        end else if (mem_req_o) begin
          state_d = WAIT_GNT;
          hold_d  = fetch_q;
        end else if (!req_en_i) begin
          state_d = IDLE;
        end
      end
      WAIT_GNT: begin
        if (fire) state_d = req_en_i ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fire && !stale_q) fetch_d = fetch_q + 32'd4;
    if (fire) stale_d = 1'b0;
    if (rv_land && (disc_q != '0)) disc_d = disc_q - CW'(1);
    if (fire && stale_q) disc_d = disc_d + CW'(1);
    if (rsp_push) hw_d = 1'b0;
    // Held requests cannot be retracted; drop them once granted.
    if (redirect_i) begin
      fetch_d = redirect_addr_i & INSTR_ALIGN_MASK;
      hw_d    = redirect_addr_i[1];
      disc_d  = outst - CW'(rv_land) + CW'(fire);
      if (mem_req_o && !mem_gnt_i) stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      fetch_q <= PC_RESET & INSTR_ALIGN_MASK;
      hold_q  <= PC_RESET & INSTR_ALIGN_MASK;
      disc_q  <= '0;
      stale_q <= 1'b0;
      hw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      hold_q  <= hold_d;
      disc_q  <= disc_d;
      stale_q <= stale_d;
      hw_q    <= hw_d;
    end
  end

  pf_fifo #(
    .DEPTH (NUM_REQS),
    .WIDTH (32)
  ) u_tag_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (1'b0),
    .push_i  (fire),
    .data_i  (mem_addr_o),
    .pop_i   (rv_land),
    .data_o  (tag_addr),
    .count_o (outst)
  );

  pf_fifo #(
    .DEPTH (NUM_REQS),
    .WIDTH ($bits(pf_entry_t))
  ) u_rsp_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (redirect_i),
    .push_i  (rsp_push),
    .data_i  (rsp_in),
    .pop_i   (rsp_pop),
    .data_o  (rsp_head),
    .count_o (rsp_cnt)
  );

  assign out_rdata_o = rsp_head.rdata;
  assign out_addr_o  = rsp_head.addr;
  assign out_err_o   = rsp_head.err;

endmodule

// File: tb/tb_instr_prefetch_ctrl.sv
// tb_instr_prefetch_ctrl: directed vector table plus
// hand-written redirect/error/stray-response sequences.
module tb_instr_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_en_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;

  always #5 clk = ~clk;

  instr_prefetch_ctrl #(
    .PC_RESET (32'h0),
    .NUM_REQS (2)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_en_i        (req_en_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .mem_req_o       (mem_req_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_addr_o      (mem_addr_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_err_i       (mem_err_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_rdata_o     (out_rdata_o),
    .out_addr_o      (out_addr_o),
    .out_err_o       (out_err_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic        err;
  } exp_t;

  typedef struct {
    bit          rst;
    logic        rdy;
    logic        req;
    logic [31:0] maddr;
    logic        val;
    logic [31:0] oaddr;
  } vec_t;

  int    checks = 0;
  int    fails = 0;
  int    cyc = 0;
  pend_t pq[$];
  exp_t  eq[$];
  vec_t  tv[15];
  logic  gnt_en = 1'b1;
  int    rv_dly = 1;
  bit    err_on = 0;
  logic [31:0] err_addr = '0;
  bit    stray = 0;
  bit    sb_on = 0;
  bit    ovf = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h need 0x%0h", nm, act, exp);
    end
  endtask

  // Bus responder and output scoreboard, one clock per call.
  task automatic cycle();
    pend_t p;
    exp_t  e;
    #1;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = '0;
    if (stray) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_BAD0;
      stray        = 0;
    end else if (pq.size() > 0 && pq[0].due == cyc) begin
      p = pq.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = memw(p.addr);
      mem_err_i    = err_on && (p.addr == err_addr);
    end
    mem_gnt_i = gnt_en;
    #1;
    if (mem_req_o && mem_gnt_i)
      pq.push_back('{addr: mem_addr_o, due: cyc + rv_dly});
    if (sb_on && out_valid_o && out_ready_i && eq.size() > 0) begin
      e = eq.pop_front();
      chk("sb_addr", out_addr_o, e.addr);
      chk("sb_data", out_rdata_o, memw(e.addr & 32'hFFFF_FFFC));
      chk("sb_err", 32'(out_err_o), 32'(e.err));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset(input bit chk_rst);
    rstn = 1'b0;
    req_en_i = 1'b1;
    redirect_i = 1'b0;
    out_ready_i = 1'b1;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i = 1'b0;
    gnt_en = 1'b1;
    rv_dly = 1;
    err_on = 0;
    stray = 0;
    sb_on = 0;
    pq.delete();
    eq.delete();
    repeat (2) @(posedge clk);
    #1;
    if (chk_rst) begin
      chk("rst_req", 32'(mem_req_o), 0);
      chk("rst_maddr", mem_addr_o, 0);
      chk("rst_valid", 32'(out_valid_o), 0);
      chk("rst_rdata", out_rdata_o, 0);
      chk("rst_oaddr", out_addr_o, 0);
      chk("rst_err", 32'(out_err_o), 0);
    end
    rstn = 1'b1;
    cyc = 0;
  endtask

  task automatic drain_and_close(input string nm);
    req_en_i = 1'b0;
    run(12);
    chk({nm, "_stream_done"}, eq.size(), 0);
    chk({nm, "_disc_zero"}, 32'(dut.disc_q), 0);
  endtask

  always @(negedge clk) begin
    if (rstn && dut.rsp_push && dut.rsp_cnt == 2 && !dut.rsp_pop)
      ovf = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1, 1, 0, 32'h0,  0, 32'h0};
    tv[1]  = '{0, 1, 1, 32'h0,  0, 32'h0};
    tv[2]  = '{0, 1, 1, 32'h4,  0, 32'h0};
    tv[3]  = '{0, 1, 1, 32'h8,  1, 32'h0};
    tv[4]  = '{0, 1, 1, 32'hC,  1, 32'h4};
    tv[5]  = '{0, 1, 1, 32'h10, 1, 32'h8};
    tv[6]  = '{1, 0, 0, 32'h0,  0, 32'h0};
    tv[7]  = '{0, 0, 1, 32'h0,  0, 32'h0};
    tv[8]  = '{0, 0, 1, 32'h4,  0, 32'h0};
    tv[9]  = '{0, 0, 0, 32'h0,  1, 32'h0};
    tv[10] = '{0, 0, 0, 32'h0,  1, 32'h0};
    tv[11] = '{0, 0, 0, 32'h0,  1, 32'h0};
    tv[12] = '{0, 1, 1, 32'h8,  1, 32'h0};
    tv[13] = '{0, 1, 1, 32'hC,  1, 32'h4};
    tv[14] = '{0, 1, 1, 32'h10, 1, 32'h8};

    for (int i = 0; i < 15; i++) begin
      if (tv[i].rst) do_reset(i == 0);
      out_ready_i = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_req", i), 32'(mem_req_o), 32'(tv[i].req));
      if (tv[i].req)
        chk($sformatf("v%0d_maddr", i), mem_addr_o, tv[i].maddr);
      chk($sformatf("v%0d_valid", i), 32'(out_valid_o), 32'(tv[i].val));
      if (tv[i].val) begin
        chk($sformatf("v%0d_oaddr", i), out_addr_o, tv[i].oaddr);
        chk($sformatf("v%0d_rdata", i), out_rdata_o, memw(tv[i].oaddr));
        chk($sformatf("v%0d_err", i), 32'(out_err_o), 0);
      end
      cycle();
    end

    // Redirect to 0x102 while the first request waits for grant.
    do_reset(0);
    gnt_en = 1'b0;
    sb_on = 1;
    eq.push_back('{32'h102, 1'b0});
    eq.push_back('{32'h104, 1'b0});
    eq.push_back('{32'h108, 1'b0});
    run(2);
    redirect_i = 1'b1;
    redirect_addr_i = 32'h102;
    #1;
    chk("rd_held_req", 32'(mem_req_o), 1);
    chk("rd_held_addr", mem_addr_o, 32'h0);
    cycle();
    redirect_i = 1'b0;
    #1;
    chk("rd_held_req2", 32'(mem_req_o), 1);
    chk("rd_held_addr2", mem_addr_o, 32'h0);
    cycle();
    gnt_en = 1'b1;
    #1;
    chk("rd_gnt_addr", mem_addr_o, 32'h0);
    cycle();
    #1;
    chk("rd_new_req", 32'(mem_req_o), 1);
    chk("rd_new_addr", mem_addr_o, 32'h100);
    cycle();
    #1;
    chk("rd_stale_drop", 32'(out_valid_o), 0);
    cycle();
    run(8);
    drain_and_close("rd");

    // Redirect with two responses still in flight.
    do_reset(0);
    rv_dly = 4;
    sb_on = 1;
    eq.push_back('{32'h200, 1'b0});
    eq.push_back('{32'h204, 1'b0});
    eq.push_back('{32'h208, 1'b0});
    run(3);
    #1;
    chk("fl_no_credit", 32'(mem_req_o), 0);
    redirect_i = 1'b1;
    redirect_addr_i = 32'h200;
    cycle();
    redirect_i = 1'b0;
    #1;
    chk("fl_disc_two", 32'(dut.disc_q), 2);
    chk("fl_req_low", 32'(mem_req_o), 0);
    cycle();
    run(20);
    drain_and_close("fl");

    // Error on the word at 0x8 only.
    do_reset(0);
    err_on = 1;
    err_addr = 32'h8;
    sb_on = 1;
    eq.push_back('{32'h0,  1'b0});
    eq.push_back('{32'h4,  1'b0});
    eq.push_back('{32'h8,  1'b1});
    eq.push_back('{32'hC,  1'b0});
    eq.push_back('{32'h10, 1'b0});
    run(12);
    drain_and_close("er");

    // Redirect, rvalid and pop all in one cycle.
    do_reset(0);
    sb_on = 1;
    eq.push_back('{32'h0,   1'b0});
    eq.push_back('{32'h300, 1'b0});
    eq.push_back('{32'h304, 1'b0});
    run(3);
    #1;
    chk("tr_head_valid", 32'(out_valid_o), 1);
    redirect_i = 1'b1;
    redirect_addr_i = 32'h300;
    cycle();
    redirect_i = 1'b0;
    #1;
    chk("tr_valid_low", 32'(out_valid_o), 0);
    chk("tr_fifo_empty", 32'(dut.rsp_cnt), 0);
    chk("tr_disc_one", 32'(dut.disc_q), 1);
    chk("tr_req", 32'(mem_req_o), 1);
    chk("tr_addr", mem_addr_o, 32'h300);
    cycle();
    run(10);
    drain_and_close("tr");

    // Stray response with nothing outstanding.
    do_reset(0);
    req_en_i = 1'b0;
    stray = 1;
    cycle();
    #1;
    chk("st_valid", 32'(out_valid_o), 0);
    req_en_i = 1'b1;
    cycle();
    #1;
    chk("st_req", 32'(mem_req_o), 1);
    chk("st_addr", mem_addr_o, 32'h0);
    sb_on = 1;
    eq.push_back('{32'h0, 1'b0});
    eq.push_back('{32'h4, 1'b0});
    run(6);
    drain_and_close("st");

    chk("no_overflow", 32'(ovf), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_ctrl.md
Name: instr_prefetch_ctrl

Overview:
- Upstream neighbour of the fetch stage.
- Issues word-aligned instruction reads on the req/gnt/rvalid instruction bus, tracking up to NUM_REQS outstanding transactions.
- Buffers returned words in a small response FIFO and presents them to fetch with a valid/ready handshake.
- On a PC redirect (trap, branch or jump), restarts at the new address and silently drops in-flight responses.

Parameters:
- PC_RESET, 32'h0000_0000, first fetch address after reset.
- NUM_REQS, 2, maximum outstanding bus transactions; also the response FIFO depth.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_en_i  in  1  allows new bus requests; low stops issuing; in-flight responses still land.
- redirect_i  in  1  PC change, single-cycle pulse.
- redirect_addr_i  in  32  new PC; bit1 may be set, bit0 ignored.
- mem_req_o  out  1  bus request.
- mem_gnt_i  in  1  bus grant.
- mem_addr_o  out  32  bus word address, bits[1:0]=0.
- mem_rvalid_i  in  1  response valid; cannot be back-pressured.
- mem_rdata_i  in  32  response data.
- mem_err_i  in  1  response error, qualified by rvalid.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  fetch consumes the head.
- out_rdata_o  out  32  head word.
- out_addr_o  out  32  head address; bit1 = halfword start offset on the first word after a redirect, else 0.
- out_err_o  out  1  head word returned with error.

Behaviour:
- Reset:
  - mem_req_o=0, mem_addr_o=PC_RESET&~3.
  - out_valid_o=0, out_rdata_o=0, out_addr_o=0, out_err_o=0.
  - Counters and FIFO empty; state IDLE.
- State machine:
  - IDLE: mem_req_o=0. Go to REQ when req_en_i=1 and credit available.
  - REQ: mem_req_o=1.
    - On gnt: fetch_addr+=4, outstanding++; stay in REQ if credit remains and req_en_i=1, else IDLE.
    - Without gnt: hold addr and req stable, go to WAIT_GNT.
  - WAIT_GNT: req and addr held until gnt; req_en_i falling does not retract the request. On gnt, same transition as REQ.
- Credit: fifo_count + outstanding < NUM_REQS. Every granted word therefore has a guaranteed FIFO slot. rvalid arriving when the FIFO is full is impossible by construction; the bench asserts it never happens.
- Latency:
  - Request is asserted the cycle after reset release, given req_en_i=1.
  - Response with rvalid in cycle N gives out_valid_o in cycle N+1 (registered FIFO, no bypass).
- Throughput: one grant per cycle is sustainable when gnt is held high and fetch drains every cycle.
- Response:
  - rvalid with discard_cnt>0: discard_cnt--, outstanding--, word dropped.
  - Otherwise: push {rdata, err, tag_addr}, outstanding--.
  - Responses return in order; tag addresses come from an internal address FIFO written at grant.
- Pop: out_valid_o & out_ready_i. Push and pop in the same cycle keeps the count.
- Redirect:
  - fetch_addr <= redirect_addr_i&~3, and a halfword flag is set from redirect_addr_i[1].
  - FIFO flushed (count=0, out_valid_o=0 next cycle).
  - discard_cnt <= outstanding minus the rvalid landing this cycle.
  - In REQ/WAIT_GNT without gnt: the held request stays issued (bus rule); it is counted into discard_cnt when granted. Then the first new request goes to the redirect address.
  - Redirect in the same cycle as gnt: the granted transaction is counted as discarded.
  - The first word pushed after a redirect carries out_addr_o[1]=halfword flag; the flag then clears.
- Error: err is passed through per word; requests continue (fetch/trap logic decides).
- Arithmetic: address increments wrap modulo 2^32. The outstanding counter is $clog2(NUM_REQS+1) bits wide; discard_cnt has the same width.
- Reset mid-transaction clears everything. Stray rvalid after reset with outstanding=0 is ignored.

Decomposition:
- Shared package (core_pkg) holds:
  - typedef pf_state_e {IDLE, REQ, WAIT_GNT}
  - struct pf_entry_t {rdata[31:0], addr[31:0], err}
  - the constant INSTR_ALIGN_MASK.
- One sub-module: pf_fifo. Synchronous, parameterised depth, push/pop/flush, count output. Instantiated twice: response FIFO and granted-address FIFO.

Test Plan:
- Reset release, req_en_i=1, gnt=1, rvalid 1 cycle after each gnt, ready=1 -> addresses 0x0,0x4,0x8…; out_valid_o rises 2 cycles after the first grant; rdata matches memory model.
- ready=0, NUM_REQS=2 -> exactly 2 grants, mem_req_o then drops; after ready=1 the first pop restarts requests at 0x8.
- gnt held low 3 cycles while redirect_i to 0x102 -> addr 0x0 held until gnt; that response is dropped; next request 0x100; first output has out_addr_o=0x102, the next 0x104.
- Redirect with 2 outstanding (rvalid delayed 4 cycles) -> both responses dropped, discard_cnt returns to 0, only 0x200-stream words are output.
- rvalid with mem_err_i=1 for addr 0x8 -> out_err_o=1 only on that word; the stream continues at 0xC.
- Redirect, rvalid and pop all in the same cycle -> no push, FIFO empty next cycle, counter consistent; assertion on no overflow holds.
